// File: rtl/sopc_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module : sopc_irq_pkg
// Brief  : Shared constants and helpers for the SOPC interrupt aggregator.
// Rev    : 1.0 - initial release
// ============================================================================
package sopc_irq_pkg;

    localparam int IRQ_DATA_W  = 16;
    localparam int IRQ_MAX_SRC = 16;

    localparam logic [2:0] IRQ_ADDR_PENDING = 3'd0;
    localparam logic [2:0] IRQ_ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] IRQ_ADDR_MODE    = 3'd2;
    localparam logic [2:0] IRQ_ADDR_VECTOR  = 3'd3;
    localparam logic [2:0] IRQ_ADDR_RAW     = 3'd4;
    localparam logic [2:0] IRQ_ADDR_EVCOUNT = 3'd5;

    // Index of the lowest set bit, 0 when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [IRQ_DATA_W-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = IRQ_DATA_W - 1; i >= 0; i--) begin
            if (v[i]) idx = i[3:0];
        end
        return idx;
    endfunction

endpackage : sopc_irq_pkg
`default_nettype wire

// File: rtl/sopc_irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : sopc_irq_sync_edge
// Brief  : Optional per-source synchroniser plus rising-edge detector.
// Rev    : 1.0 - initial release
// ============================================================================
module sopc_irq_sync_edge #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_src,
    output logic s,
    output logic edge_pulse
);

    logic r_prev;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s = irq_src;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= irq_src;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // prev resets low so a line held high through reset produces one edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= s;
        end
    end

    assign edge_pulse = s & ~r_prev;

endmodule : sopc_irq_sync_edge
`default_nettype wire

// File: rtl/sopc_system_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module : sopc_system_irq_aggregator
// Brief  : Avalon-MM interrupt aggregator with mask, edge/level mode,
//          priority vector and saturating event counter.
// Rev    : 1.0 - initial release
// ============================================================================
module sopc_system_irq_aggregator
    import sopc_irq_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [IRQ_DATA_W-1:0] writedata,
    output logic [IRQ_DATA_W-1:0] readdata,
    input  logic [NUM_IRQ-1:0]    irq_in,
    output logic                  irq
);

    localparam logic [IRQ_DATA_W-1:0] c_EV_MAX = '1;

    logic [NUM_IRQ-1:0]    w_s;
    logic [NUM_IRQ-1:0]    w_edge;
    logic [NUM_IRQ-1:0]    w_wdata;
    logic [NUM_IRQ-1:0]    w_w1c;
    logic [NUM_IRQ-1:0]    w_mode_chg;
    logic [NUM_IRQ-1:0]    w_pend_nxt;
    logic [NUM_IRQ-1:0]    w_active;
    logic [IRQ_DATA_W-1:0] w_active_ext;
    logic [IRQ_DATA_W-1:0] w_vector;
    logic [IRQ_DATA_W-1:0] w_rdata;
    logic                  w_wr;
    logic                  w_wr_pend;
    logic                  w_wr_en;
    logic                  w_wr_mode;
    logic                  w_wr_evc;
    logic                  w_ev;
    logic                  w_unused_wdata;

    logic [NUM_IRQ-1:0]    r_pending;
    logic [NUM_IRQ-1:0]    r_enable;
    logic [NUM_IRQ-1:0]    r_mode;
    logic [IRQ_DATA_W-1:0] r_evcount;
    logic [IRQ_DATA_W-1:0] r_readdata;
    logic                  r_irq;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            sopc_irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge (
                .clk        (clk),
                .reset_n    (reset_n),
                .irq_src    (irq_in[gi]),
                .s          (w_s[gi]),
                .edge_pulse (w_edge[gi])
            );
        end
    endgenerate

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_pend = w_wr && (address == IRQ_ADDR_PENDING);
    assign w_wr_en   = w_wr && (address == IRQ_ADDR_ENABLE);
    assign w_wr_mode = w_wr && (address == IRQ_ADDR_MODE);
    assign w_wr_evc  = w_wr && (address == IRQ_ADDR_EVCOUNT);

    assign w_wdata        = writedata[NUM_IRQ-1:0];
    assign w_unused_wdata = ^writedata;

    assign w_w1c      = w_wr_pend ? w_wdata : '0;
    assign w_mode_chg = w_wr_mode ? (w_wdata ^ r_mode) : '0;

    // Edge bits: set beats W1C. Level bits follow s. A mode flip clears the bit.
    assign w_pend_nxt = ((r_mode & ((r_pending & ~w_w1c) | w_edge)) |
                         (~r_mode & w_s)) & ~w_mode_chg;

    assign w_ev = |(w_edge & r_mode);

    assign w_active     = r_pending & r_enable;
    assign w_active_ext = IRQ_DATA_W'(w_active);
    assign w_vector     = {|w_active, 11'd0, lowest_set(w_active_ext)};

    always_comb begin
        w_rdata = '0;
        case (address)
            IRQ_ADDR_PENDING: w_rdata = IRQ_DATA_W'(r_pending);
            IRQ_ADDR_ENABLE:  w_rdata = IRQ_DATA_W'(r_enable);
            IRQ_ADDR_MODE:    w_rdata = IRQ_DATA_W'(r_mode);
            IRQ_ADDR_VECTOR:  w_rdata = w_vector;
            IRQ_ADDR_RAW:     w_rdata = IRQ_DATA_W'(w_s);
            IRQ_ADDR_EVCOUNT: w_rdata = r_evcount;
            default:          w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_mode     <= '0;
            r_evcount  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_readdata <= w_rdata;
            r_irq      <= |w_active;

            if (w_wr_en) begin
                r_enable <= w_wdata;
            end
            if (w_wr_mode) begin
                r_mode <= w_wdata;
            end

            // A clearing write that coincides with an event restarts at 1
            if (w_wr_evc) begin
                r_evcount <= IRQ_DATA_W'(w_ev);
            end else if (w_ev && (r_evcount != c_EV_MAX)) begin
                r_evcount <= r_evcount + IRQ_DATA_W'(1);
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule : sopc_system_irq_aggregator
`default_nettype wire

// File: tb/tb_sopc_system_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module : tb_sopc_system_irq_aggregator
// Brief  : Self-checking bench with a rule-level model of the aggregator.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sopc_system_irq_aggregator;

    localparam int          NUM_IRQ = 8;
    localparam logic [15:0] MASK    = 16'h00FF;

    typedef struct packed {
        logic [15:0] pend;
        logic [15:0] en;
        logic [15:0] mode;
        logic [15:0] prev;
        logic [15:0] cnt;
        logic [15:0] rd;
        logic        irq;
    } mstate_t;

    logic               clk        = 1'b0;
    logic               reset_n    = 1'b0;
    logic [2:0]         address    = 3'd0;
    logic               chipselect = 1'b0;
    logic               write_n    = 1'b1;
    logic [15:0]        writedata  = 16'd0;
    logic [15:0]        readdata;
    logic [NUM_IRQ-1:0] irq_in     = '0;
    logic               irq;

    int      n_checks = 0;
    int      n_fail   = 0;
    mstate_t m;

    always #5 clk = ~clk;

    sopc_system_irq_aggregator #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    // One clock of the register map, derived directly from the bit rules.
    function automatic mstate_t step(mstate_t c, logic [2:0] a, logic wr,
                                     logic [15:0] d, logic [15:0] s);
        mstate_t     n;
        logic        ev;
        logic        rise;
        logic [15:0] act;
        n   = c;
        ev  = 1'b0;
        act = c.pend & c.en;
        case (a)
            3'd0: n.rd = c.pend;
            3'd1: n.rd = c.en;
            3'd2: n.rd = c.mode;
            3'd3: begin
                n.rd = 16'd0;
                for (int i = 15; i >= 0; i--) if (act[i]) n.rd = 16'h8000 | 16'(i);
            end
            3'd4: n.rd = s;
            3'd5: n.rd = c.cnt;
            default: n.rd = 16'd0;
        endcase
        n.irq = (act != 16'd0);
        for (int i = 0; i < NUM_IRQ; i++) begin
            rise = s[i] & ~c.prev[i];
            if (c.mode[i]) begin
                if (rise) n.pend[i] = 1'b1;
                else if (wr && a == 3'd0 && d[i]) n.pend[i] = 1'b0;
                ev = ev | rise;
            end else begin
                n.pend[i] = s[i];
            end
            if (wr && a == 3'd2 && d[i] != c.mode[i]) n.pend[i] = 1'b0;
        end
        if (wr && a == 3'd1) n.en   = d & MASK;
        if (wr && a == 3'd2) n.mode = d & MASK;
        if (wr && a == 3'd5) n.cnt = ev ? 16'd1 : 16'd0;
        else if (ev) n.cnt = (c.cnt == 16'hFFFF) ? c.cnt : c.cnt + 16'd1;
        n.prev = s;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else m <= step(m, address, chipselect & ~write_n, writedata, 16'(irq_in));
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                chk("model_readdata", readdata, m.rd);
                chk("model_irq", 16'(irq), 16'(m.irq));
            end
        end
    end

    task automatic cyc(input logic [2:0] a, input logic w, input logic [15:0] d);
        @(negedge clk);
        address    = a;
        chipselect = w;
        write_n    = ~w;
        writedata  = d;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [2:0] a, input logic [15:0] exp, input string nm);
        cyc(a, 1'b0, 16'd0);
        after_edge();
        chk(nm, readdata, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_readdata", readdata, 16'h0000);
        chk("reset_irq", 16'(irq), 16'h0000);
        cyc(3'd0, 1'b0, 16'd0); reset_n = 1'b1;

        // edge capture and W1C
        cyc(3'd2, 1'b1, 16'h0001);
        cyc(3'd1, 1'b1, 16'h0001);
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'h01;
        after_edge(); chk("edge_irq_pre", 16'(irq), 16'h0000);
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'h00;
        after_edge();
        chk("edge_irq_rise", 16'(irq), 16'h0001);
        chk("edge_pending", readdata, 16'h0001);
        cyc(3'd0, 1'b1, 16'h0001);
        after_edge(); chk("w1c_irq_hold", 16'(irq), 16'h0001);
        cyc(3'd0, 1'b0, 16'd0);
        after_edge();
        chk("w1c_irq_fall", 16'(irq), 16'h0000);
        chk("w1c_pending", readdata, 16'h0000);

        // level mode and priority
        cyc(3'd2, 1'b1, 16'h0000);
        cyc(3'd1, 1'b1, 16'h00FF); irq_in = 8'h24;
        peek(3'd3, 16'h8002, "level_vector");
        cyc(3'd0, 1'b1, 16'hFFFF);
        peek(3'd0, 16'h0024, "level_w1c_ignored");
        peek(3'd4, 16'h0024, "raw");
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'h00;
        after_edge(); chk("level_irq_still", 16'(irq), 16'h0001);
        cyc(3'd0, 1'b0, 16'd0);
        after_edge(); chk("level_irq_off", 16'(irq), 16'h0000);

        // set/clear collision on bit 3
        cyc(3'd2, 1'b1, 16'h0008);
        cyc(3'd0, 1'b1, 16'h0008); irq_in = 8'h08;
        peek(3'd0, 16'h0008, "collision_set_wins");
        cyc(3'd0, 1'b1, 16'h0008); irq_in = 8'h00;
        peek(3'd0, 16'h0000, "collision_cleared");

        // mask
        cyc(3'd1, 1'b1, 16'h0000);
        cyc(3'd2, 1'b1, 16'h00FF);
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'hFF;
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'h00;
        peek(3'd0, 16'h00FF, "mask_pending");
        chk("mask_irq_low", 16'(irq), 16'h0000);
        peek(3'd3, 16'h0000, "mask_vector");
        peek(3'd2, 16'h00FF, "mode_readback");
        cyc(3'd1, 1'b1, 16'h0080);
        peek(3'd3, 16'h8007, "unmask_vector");
        chk("unmask_irq", 16'(irq), 16'h0001);

        // event counter
        cyc(3'd5, 1'b1, 16'h0000);
        peek(3'd5, 16'h0000, "ev_cleared");
        for (int k = 0; k < 70000; k++) begin
            cyc(3'd0, 1'b0, 16'd0);
            irq_in = k[0] ? 8'hAA : 8'h55;
        end
        peek(3'd5, 16'hFFFF, "ev_saturate");
        cyc(3'd5, 1'b1, 16'h0000); irq_in = 8'h00;
        cyc(3'd0, 1'b0, 16'd0);    irq_in = 8'h07;
        peek(3'd5, 16'h0001, "ev_three_edges");
        cyc(3'd0, 1'b0, 16'd0);    irq_in = 8'h00;
        cyc(3'd0, 1'b0, 16'd0);    irq_in = 8'h08;
        peek(3'd5, 16'h0002, "ev_second");
        cyc(3'd5, 1'b1, 16'h0000); irq_in = 8'h10;
        peek(3'd5, 16'h0001, "ev_clear_with_edge");

        // asynchronous reset mid-operation, then mode change on bit 1
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'h02; reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", readdata, 16'h0000);
        chk("async_reset_irq", 16'(irq), 16'h0000);
        repeat (2) cyc(3'd0, 1'b0, 16'd0);
        cyc(3'd0, 1'b0, 16'd0); reset_n = 1'b1;
        peek(3'd0, 16'h0002, "post_reset_level");
        peek(3'd5, 16'h0000, "post_reset_evcount");
        cyc(3'd2, 1'b1, 16'h0002);
        peek(3'd0, 16'h0000, "to_edge_clears");
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'h00;
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'h02;
        peek(3'd0, 16'h0002, "edge_once");
        cyc(3'd2, 1'b1, 16'h0000);
        peek(3'd0, 16'h0000, "to_level_clears");
        peek(3'd0, 16'h0002, "level_tracks_s");
        cyc(3'd0, 1'b0, 16'd0); irq_in = 8'h00;
        peek(3'd0, 16'h0000, "level_tracks_low");
        peek(3'd6, 16'h0000, "unmapped_addr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sopc_system_irq_aggregator
`default_nettype wire
